rx_command_parser: RTL and testbench
====================================

# rx_command_parser

Sequencing controller that sits directly behind the UART byte receiver and turns its raw byte stream into validated minesweeper game commands. It detects each completed byte from the receiver's `rxdata`/`rxfinish` pair, frames fixed-length packets, and range-checks them. With checksumming enabled it also verifies a checksum. It then presents one command at a time to the game core over a valid/ready handshake. Malformed, stale or dropped packets are reported through a one-cycle error strobe with a code.

## Interface
- `ROWS`, default 16: number of board rows; a legal row index is 0..ROWS-1.
- `COLS`, default 16: number of board columns; a legal column index is 0..COLS-1.
- `TIMEOUT`, default 100000: maximum number of clock cycles allowed between bytes of one packet. Must be ≥ 1.
- `clock` input, 1 bit: the single clock; all state updates on its rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset (`reset == 0` resets the block).
- `rxdata` input, 8 bits: byte from the receiver; valid when `rxfinish` rises.
- `rxfinish` input, 1 bit: receiver done level. It falls at start-bit detection and rises after the stop bit.
- `cmd_valid` output, 1 bit: a command is held on `cmd_op`, `cmd_row` and `cmd_col`.
- `cmd_ready` input, 1 bit: the game core accepts the command.
- `cmd_op` output, 2 bits: 1 = reveal, 2 = flag, 3 = new game.
- `cmd_row` output, 8 bits: row index of the command.
- `cmd_col` output, 8 bits: column index of the command.
- `err` output, 1 bit: one-cycle strobe signalling an error.
- `err_code` output, 3 bits: cause of the error; valid only while `err` is 1.

## Operation
- **Byte strobe.**
  - `rxfinish` is registered into `fin_q`; a byte is accepted at an edge where `rxfinish == 1` and `fin_q == 0`.
  - `fin_q` resets to 1, so a high `rxfinish` after reset never yields a spurious byte.
- **Packet format:** `0xA5` sync, then opcode, then row, then col, then (with checksum) csum.
  - csum = opcode ^ row ^ col.
- **Parser FSM states:** SYNC → OP → ROW → COL → (CSUM) → SYNC, advancing one state per accepted byte.
  - SYNC: any byte other than `0xA5` is discarded silently.
  - `0xA5` in any state other than SYNC is treated as ordinary data; there is no mid-packet resync.
- **Validation** is performed when the final byte is accepted. Error codes:
  - 1: opcode is 0.
  - 2: row ≥ ROWS or col ≥ COLS. This check is skipped for op 3; new game forces row = col = 0.
  - 3: checksum mismatch.
  - 4: timeout.
  - 5: overflow.
- **Output register (depth 1):** a valid packet loads the register and sets `cmd_valid`.
  - The register and `cmd_valid` are held until a cycle with `cmd_valid && cmd_ready`.
  - If a valid packet completes while `cmd_valid == 1` and `cmd_ready == 0`, the new packet is dropped and err 5 is raised.
  - If `cmd_ready == 1` on that same edge, the new packet is loaded and no error is raised.
- **Timeout counter.**
  - Reloads to TIMEOUT-1 on every accepted byte.
  - Decrements every cycle while the FSM is not in SYNC.
  - When the counter is at 0 in a non-SYNC state with no byte accepted that cycle: the FSM goes to SYNC and err 4 is raised.
  - A byte accepted on the expiry cycle wins: the counter reloads and no error is raised.
  - Counter width is $clog2(TIMEOUT)+1.
- **Reset (asynchronous, mid-packet or otherwise):**
  - FSM = SYNC; `fin_q` = 1; `cmd_valid` = 0.
  - `cmd_op`, `cmd_row`, `cmd_col` = 0; `err` = 0; `err_code` = 0.
  - Any partial packet is discarded.

## Timing
- **Byte latency:** a `rxfinish` rise sampled at edge k updates FSM state at edge k+1.
- **Command latency:** `cmd_valid` is high from edge k+1, where k is the edge sampling the final byte's `rxfinish` rise. The error strobe follows the same timing.
- **Handshake:**
  - `cmd_valid` never drops without `cmd_ready`.
  - Payload is stable while `cmd_valid` is 1.
  - `cmd_valid` may be high in the cycle following the transfer only if a new packet loaded on the transfer edge.
- **Error strobe:** `err` is high for exactly one cycle per event; at most one error per edge.

## Configuration
- `RX_CMD_CHECKSUM_EN` defined:
  - Packets are 5 bytes; the CSUM state exists; err 3 is possible.
- Not defined:
  - Packets are 4 bytes; COL is the final state; err 3 is never produced.

## Structure
- **Shared package `vs_cmd_pkg`:**
  - `SYNC_BYTE` = 8'hA5.
  - Opcode constants `OP_REVEAL`, `OP_FLAG`, `OP_NEW`.
  - Error-code constants `ERR_OP`, `ERR_RANGE`, `ERR_CSUM`, `ERR_TIMEOUT`, `ERR_OVF`.
  - Parser state enum.
- **Sub-module `rx_byte_strobe`:** the `fin_q` register and rise detector.
  - Outputs a one-cycle `byte_stb` and a registered `byte_q` (8 bits).
- Everything else stays in `rx_command_parser`.

## Test plan
- **Legal reveal.** With checksum enabled, bytes A5 01 03 07 05 with `cmd_ready` = 1 → one `cmd_valid` with op 1, row 3, col 7; cycle after the final strobe; no `err`.
- **Out-of-range row.** With ROWS = 16, bytes A5 02 10 00 12 → `err_code` 2, no `cmd_valid`, parser back in SYNC.
- **Checksum mismatch.** Bytes A5 01 01 01 00 → `err_code` 3. A following A5 03 00 00 03 → op 3, row 0, col 0.
- **Timeout.** With TIMEOUT = 50, bytes A5 01 then silence for 50 cycles → `err_code` 4 once. A late 05 byte is then discarded as non-sync.
- **Overflow.** With `cmd_ready` held at 0, two back-to-back legal packets → first is held stable, second raises `err_code` 5. Raising `cmd_ready` transfers the first only.
- **Reset mid-packet.** After A5 01, pull `reset` low → all outputs are 0. After release, a stale `rxfinish` level produces no byte, and a complete packet parses normally.

Source files
------------

// File: rtl/vs_cmd_pkg.sv
// Shared constants and parser state type for the UART command path.
package vs_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [1:0] OP_REVEAL = 2'd1;
    localparam logic [1:0] OP_FLAG   = 2'd2;
    localparam logic [1:0] OP_NEW    = 2'd3;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_OP      = 3'd1;
    localparam logic [2:0] ERR_RANGE   = 3'd2;
    localparam logic [2:0] ERR_CSUM    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;
    localparam logic [2:0] ERR_OVF     = 3'd5;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_OP,
        ST_ROW,
        ST_COL,
        ST_CSUM
    } parser_state_t;

endpackage

// File: rtl/rx_byte_strobe.sv
// Turns the receiver's done level into a one-cycle byte strobe plus a held copy of the byte.
module rx_byte_strobe (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rxdata,
    input  logic       rxfinish,
    output logic       byte_stb,
    output logic [7:0] byte_q
);

    logic       r_fin_q;
    logic       r_stb;
    logic [7:0] r_byte;
    logic       w_rise;

    assign w_rise = rxfinish & ~r_fin_q;

    // r_fin_q comes out of reset high so a receiver already idling high is not seen as a rise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fin_q <= 1'b1;
            r_stb   <= 1'b0;
            r_byte  <= 8'h00;
        end else begin
            r_fin_q <= rxfinish;
            r_stb   <= w_rise;
            if (w_rise) begin
                r_byte <= rxdata;
            end
        end
    end

    assign byte_stb = r_stb;
    assign byte_q   = r_byte;

endmodule

// File: rtl/rx_command_parser.sv
// Frames receiver bytes into validated game commands with a depth-1 valid/ready output.
// Define RX_CMD_CHECKSUM_EN for 5-byte packets carrying an XOR checksum.
module rx_command_parser
    import vs_cmd_pkg::*;
#(
    parameter int ROWS    = 16,
    parameter int COLS    = 16,
    parameter int TIMEOUT = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rxdata,
    input  logic       rxfinish,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_op,
    output logic [7:0] cmd_row,
    output logic [7:0] cmd_col,
    output logic       err,
    output logic [2:0] err_code
);

    localparam int             TW         = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0]  TMO_RELOAD = TW'(TIMEOUT - 1);
    localparam logic [8:0]     ROW_LIM    = 9'(ROWS);
    localparam logic [8:0]     COL_LIM    = 9'(COLS);

    logic          w_byte_stb;
    logic [7:0]    w_byte_q;

    parser_state_t r_state;
    parser_state_t w_state_next;
    logic [7:0]    r_op;
    logic [7:0]    r_row;
    logic [TW-1:0] r_tmo;

    logic          w_pkt_done;
    logic          w_load;
    logic [2:0]    w_err_next;
    logic [7:0]    w_fin_col;
    logic          w_csum_ok;
    logic          w_op_bad;
    logic          w_range_bad;

    logic          r_cmd_valid;
    logic [1:0]    r_cmd_op;
    logic [7:0]    r_cmd_row;
    logic [7:0]    r_cmd_col;
    logic          r_err;
    logic [2:0]    r_err_code;

    rx_byte_strobe u_byte_strobe (
        .clock    (clock),
        .reset    (reset),
        .rxdata   (rxdata),
        .rxfinish (rxfinish),
        .byte_stb (w_byte_stb),
        .byte_q   (w_byte_q)
    );

`ifdef RX_CMD_CHECKSUM_EN
    logic [7:0] r_col;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_col <= 8'h00;
        end else if (w_byte_stb && r_state == ST_COL) begin
            r_col <= w_byte_q;
        end
    end

    assign w_fin_col = r_col;
    assign w_csum_ok = ((r_op ^ r_row ^ r_col) == w_byte_q);
`else
    assign w_fin_col = w_byte_q;
    assign w_csum_ok = 1'b1;
`endif

    // Opcode byte values outside 1..3 cannot be carried on the 2-bit command and are rejected.
    assign w_op_bad    = (r_op == 8'h00) || (r_op > 8'h03);
    assign w_range_bad = ({1'b0, r_row} >= ROW_LIM) || ({1'b0, w_fin_col} >= COL_LIM);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_SYNC;
            r_op    <= 8'h00;
            r_row   <= 8'h00;
            r_tmo   <= TMO_RELOAD;
        end else begin
            r_state <= w_state_next;
            if (w_byte_stb && r_state == ST_OP) begin
                r_op <= w_byte_q;
            end
            if (w_byte_stb && r_state == ST_ROW) begin
                r_row <= w_byte_q;
            end
            if (w_byte_stb) begin
                r_tmo <= TMO_RELOAD;
            end else if (r_state != ST_SYNC && r_tmo != '0) begin
                r_tmo <= r_tmo - 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pkt_done   = 1'b0;
        w_load       = 1'b0;
        w_err_next   = ERR_NONE;

        case (r_state)
            ST_SYNC: if (w_byte_stb && w_byte_q == SYNC_BYTE) w_state_next = ST_OP;
            ST_OP:   if (w_byte_stb) w_state_next = ST_ROW;
            ST_ROW:  if (w_byte_stb) w_state_next = ST_COL;
            ST_COL: begin
                if (w_byte_stb) begin
`ifdef RX_CMD_CHECKSUM_EN
                    w_state_next = ST_CSUM;
`else
                    w_state_next = ST_SYNC;
                    w_pkt_done   = 1'b1;
`endif
                end
            end
            ST_CSUM: begin
`ifdef RX_CMD_CHECKSUM_EN
                if (w_byte_stb) begin
                    w_state_next = ST_SYNC;
                    w_pkt_done   = 1'b1;
                end
`else
                w_state_next = ST_SYNC;
`endif
            end
            default: w_state_next = ST_SYNC;
        endcase

        // An accepted byte reloads the counter, so expiry only fires on an idle cycle.
        if (r_state != ST_SYNC && !w_byte_stb && r_tmo == '0) begin
            w_state_next = ST_SYNC;
            w_err_next   = ERR_TIMEOUT;
        end

        if (w_pkt_done) begin
            if (w_op_bad) begin
                w_err_next = ERR_OP;
            end else if (r_op[1:0] != OP_NEW && w_range_bad) begin
                w_err_next = ERR_RANGE;
            end else if (!w_csum_ok) begin
                w_err_next = ERR_CSUM;
            end else if (r_cmd_valid && !cmd_ready) begin
                w_err_next = ERR_OVF;
            end else begin
                w_load = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cmd_valid <= 1'b0;
            r_cmd_op    <= 2'd0;
            r_cmd_row   <= 8'h00;
            r_cmd_col   <= 8'h00;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            if (w_load) begin
                r_cmd_valid <= 1'b1;
                r_cmd_op    <= r_op[1:0];
                r_cmd_row   <= (r_op[1:0] == OP_NEW) ? 8'h00 : r_row;
                r_cmd_col   <= (r_op[1:0] == OP_NEW) ? 8'h00 : w_fin_col;
            end else if (cmd_ready) begin
                r_cmd_valid <= 1'b0;
            end
            r_err      <= (w_err_next != ERR_NONE);
            r_err_code <= w_err_next;
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd_op    = r_cmd_op;
    assign cmd_row   = r_cmd_row;
    assign cmd_col   = r_cmd_col;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule

// File: tb/tb_rx_command_parser.sv
// Scoreboard bench for rx_command_parser; adapts packet length to RX_CMD_CHECKSUM_EN.
module tb_rx_command_parser;

`ifdef RX_CMD_CHECKSUM_EN
    localparam int PKT_LEN = 5;
`else
    localparam int PKT_LEN = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rxdata = 8'h00;
    logic       rxfinish = 1'b1;
    logic       cmd_ready = 1'b1;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [7:0] cmd_row;
    logic [7:0] cmd_col;
    logic       err;
    logic [2:0] err_code;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] row;
        logic [7:0] col;
    } cmd_t;

    cmd_t       cmd_q[$];
    logic [2:0] err_q[$];
    cmd_t       exp_cmd;
    logic [2:0] exp_err;
    int         checks = 0;
    int         failures = 0;

    rx_command_parser #(
        .ROWS    (16),
        .COLS    (16),
        .TIMEOUT (50)
    ) dut (
        .clock     (clk),
        .reset     (rst_n),
        .rxdata    (rxdata),
        .rxfinish  (rxfinish),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit timed);
        @(negedge clk);
        rxfinish = 1'b0;
        repeat (2) @(negedge clk);
        rxdata   = b;
        rxfinish = 1'b1;
        if (timed) begin
            @(posedge clk);
            #1 check("lat_k_valid", 32'(cmd_valid), 32'd0);
            @(posedge clk);
            #1 check("lat_k1_valid", 32'(cmd_valid), 32'd1);
            check("lat_k1_err", 32'(err), 32'd0);
        end
        repeat (2) @(negedge clk);
    endtask

    // Sends the first n bytes of a packet; mask corrupts the checksum byte when nonzero.
    task automatic send_pkt(input logic [7:0] op, input logic [7:0] row, input logic [7:0] col,
                            input logic [7:0] mask, input int n, input bit timed);
        logic [7:0] pkt [5];
        pkt[0] = 8'hA5;
        pkt[1] = op;
        pkt[2] = row;
        pkt[3] = col;
        pkt[4] = op ^ row ^ col ^ mask;
        for (int i = 0; i < n; i++) begin
            send_byte(pkt[i], timed && (i == PKT_LEN - 1));
        end
    endtask

    function automatic logic [7:0] last_byte(input logic [7:0] op, input logic [7:0] row,
                                             input logic [7:0] col);
`ifdef RX_CMD_CHECKSUM_EN
        return op ^ row ^ col;
`else
        return col;
`endif
    endfunction

    task automatic push_cmd(input logic [1:0] op, input logic [7:0] row, input logic [7:0] col);
        cmd_t c;
        c.op  = op;
        c.row = row;
        c.col = col;
        cmd_q.push_back(c);
    endtask

    // Monitor samples after the driver's negedge updates, i.e. what the next posedge will see.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (cmd_valid && cmd_ready) begin
                    $display("cmd transfer op=%0d row=%0d col=%0d", cmd_op, cmd_row, cmd_col);
                    if (cmd_q.size() == 0) begin
                        check("spurious_cmd", 32'd1, 32'd0);
                    end else begin
                        exp_cmd = cmd_q.pop_front();
                        check("cmd_op", 32'(cmd_op), 32'(exp_cmd.op));
                        check("cmd_row", 32'(cmd_row), 32'(exp_cmd.row));
                        check("cmd_col", 32'(cmd_col), 32'(exp_cmd.col));
                    end
                end
                if (err) begin
                    $display("err strobe code=%0d", err_code);
                    if (err_q.size() == 0) begin
                        check("spurious_err", 32'(err_code), 32'd0);
                    end else begin
                        exp_err = err_q.pop_front();
                        check("err_code", 32'(err_code), 32'(exp_err));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_op", 32'(cmd_op), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Legal reveal with latency check on the final byte
        push_cmd(2'd1, 8'd3, 8'd7);
        send_pkt(8'h01, 8'h03, 8'h07, 8'h00, PKT_LEN, 1'b1);

        // Row and column range errors, then the upper boundary
        err_q.push_back(3'd2);
        send_pkt(8'h02, 8'h10, 8'h00, 8'h00, PKT_LEN, 1'b0);
        err_q.push_back(3'd2);
        send_pkt(8'h01, 8'h00, 8'h10, 8'h00, PKT_LEN, 1'b0);
        push_cmd(2'd2, 8'd15, 8'd15);
        send_pkt(8'h02, 8'h0F, 8'h0F, 8'h00, PKT_LEN, 1'b0);

        // Opcode zero
        err_q.push_back(3'd1);
        send_pkt(8'h00, 8'h01, 8'h01, 8'h00, PKT_LEN, 1'b0);

`ifdef RX_CMD_CHECKSUM_EN
        err_q.push_back(3'd3);
        send_pkt(8'h01, 8'h01, 8'h01, 8'h01, PKT_LEN, 1'b0);
        push_cmd(2'd3, 8'd0, 8'd0);
        send_pkt(8'h03, 8'h00, 8'h00, 8'h00, PKT_LEN, 1'b0);
`endif

        // New game ignores and clears out-of-range coordinates
        push_cmd(2'd3, 8'd0, 8'd0);
        send_pkt(8'h03, 8'h09, 8'h14, 8'h00, PKT_LEN, 1'b0);

        // Timeout: error lands exactly 50 idle cycles after the last consumed byte
        err_q.push_back(3'd4);
        send_pkt(8'h01, 8'h00, 8'h00, 8'h00, 2, 1'b0);
        repeat (49) @(posedge clk);
        #1 check("tmo_early_err", 32'(err), 32'd0);
        @(posedge clk);
        #1 check("tmo_err", 32'(err), 32'd1);
        check("tmo_code", 32'(err_code), 32'd4);
        send_byte(8'h05, 1'b0);
        push_cmd(2'd2, 8'd1, 8'd2);
        send_pkt(8'h02, 8'h01, 8'h02, 8'h00, PKT_LEN, 1'b0);

        // Overflow: held first packet, second dropped
        @(negedge clk);
        cmd_ready = 1'b0;
        push_cmd(2'd1, 8'd2, 8'd3);
        err_q.push_back(3'd5);
        send_pkt(8'h01, 8'h02, 8'h03, 8'h00, PKT_LEN, 1'b0);
        check("ovf_first_valid", 32'(cmd_valid), 32'd1);
        send_pkt(8'h02, 8'h04, 8'h05, 8'h00, PKT_LEN, 1'b0);
        check("ovf_hold_valid", 32'(cmd_valid), 32'd1);
        check("ovf_hold_op", 32'(cmd_op), 32'd1);
        check("ovf_hold_row", 32'(cmd_row), 32'd2);
        check("ovf_hold_col", 32'(cmd_col), 32'd3);
        @(negedge clk);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        #2 check("ovf_drained_valid", 32'(cmd_valid), 32'd0);

        // Ready arriving on the completion edge replaces the held command without error
        push_cmd(2'd1, 8'd6, 8'd6);
        push_cmd(2'd2, 8'd7, 8'd8);
        send_pkt(8'h01, 8'h06, 8'h06, 8'h00, PKT_LEN, 1'b0);
        send_pkt(8'h02, 8'h07, 8'h08, 8'h00, PKT_LEN - 1, 1'b0);
        @(negedge clk);
        rxfinish = 1'b0;
        repeat (2) @(negedge clk);
        rxdata   = last_byte(8'h02, 8'h07, 8'h08);
        rxfinish = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        #2 check("swap_valid", 32'(cmd_valid), 32'd1);
        check("swap_row", 32'(cmd_row), 32'd7);
        repeat (2) @(negedge clk);
        cmd_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-packet with a pending command and a stale high rxfinish
        cmd_ready = 1'b0;
        send_pkt(8'h02, 8'h05, 8'h06, 8'h00, PKT_LEN, 1'b0);
        send_pkt(8'h01, 8'h00, 8'h00, 8'h00, 2, 1'b0);
        @(negedge clk);
        rxdata = 8'hA5;
        rst_n  = 1'b0;
        #1 check("arst_valid", 32'(cmd_valid), 32'd0);
        check("arst_op", 32'(cmd_op), 32'd0);
        check("arst_row", 32'(cmd_row), 32'd0);
        check("arst_col", 32'(cmd_col), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        check("arst_err_code", 32'(err_code), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        cmd_ready = 1'b1;
        push_cmd(2'd1, 8'd4, 8'd4);
        send_pkt(8'h01, 8'h04, 8'h04, 8'h00, PKT_LEN, 1'b0);

        repeat (5) @(negedge clk);
        check("cmd_q_empty", 32'(cmd_q.size()), 32'd0);
        check("err_q_empty", 32'(err_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
